// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Shows two binary values (0..99) as two 2-digit decimal fields on
//            a 4-digit multiplexed 7-segment display. Each value is converted
//            to BCD by a sequential double-dabble, one shift per clock. Digits
//            are scanned with a blanking window at the start of every slot.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int SCAN_DIV       = 49_999,  // clocks per digit slot minus 1
  parameter int BLANK_CYC      = 500,     // all-off clocks at slot start
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dat1,
  input  logic [7:0] dat2,
  output logic [7:0] seg_out,
  output logic [3:0] sel
);

  localparam int                 c_cnt_w   = $clog2(SCAN_DIV + 1);
  localparam logic [c_cnt_w-1:0] c_div_max = c_cnt_w'(SCAN_DIV);
  localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK_CYC);
  localparam logic [7:0]         c_seg_off = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]         c_sel_off = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]         c_dash    = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV1  = 2'd1,
    ST_CONV2  = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_t;

  // Scan timing
  logic [c_cnt_w-1:0] r_div_cnt;
  logic [1:0]         r_idx;
  logic               r_start_pending;
  logic               w_wrap;
  logic               w_snap;
  logic [c_cnt_w-1:0] w_div_nxt;
  logic [1:0]         w_idx_nxt;

  // Converter
  conv_state_t r_state;
  conv_state_t w_state_nxt;
  logic [2:0]  r_step;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [11:0] r_bcd1;
  logic [7:0]  r_snap2;
  logic [7:0]  w_adj;
  logic [11:0] w_bcd_sh;
  logic [7:0]  w_bin_sh;
  logic        w_step_last;
  logic        w_commit;

  // Display
  logic [3:0][6:0] r_pat;
  logic [3:0][6:0] w_pat_nxt;
  logic            w_lit;
  logic [7:0]      w_seg_on;
  logic [3:0]      w_sel_on;
  logic [7:0]      r_seg_out;
  logic [3:0]      r_sel;

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Returns {tens, units}; any non-zero hundreds means out of range -> dashes
  function automatic logic [13:0] f_field(input logic [11:0] b);
    if (b[11:8] != 4'd0) return {c_dash, c_dash};
    return {f_digit(b[7:4]), f_digit(b[3:0])};
  endfunction

  assign w_wrap    = (r_div_cnt == c_div_max);
  assign w_div_nxt = w_wrap ? '0 : r_div_cnt + 1'b1;
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
  // Sample inputs once after reset and at every frame start (idx 3 -> 0)
  assign w_snap    = r_start_pending | (w_wrap & (r_idx == 2'd3));

  // Slot divider, digit index and the post-reset snapshot request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt       <= '0;
      r_idx           <= 2'd0;
      r_start_pending <= 1'b1;
    end else begin
      r_div_cnt       <= w_div_nxt;
      r_idx           <= w_idx_nxt;
      r_start_pending <= 1'b0;
    end
  end

  // Double-dabble step: add 3 to units/tens nibbles >= 5, then shift left.
  // Hundreds never exceeds 2 for an 8-bit input, so it needs no correction.
  always_comb begin
    w_adj = r_bcd[7:0];
    for (int i = 0; i < 2; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_sh = {r_bcd[10:8], w_adj, r_bin[7]};
    w_bin_sh = {r_bin[6:0], 1'b0};
  end

  assign w_step_last = (r_step == 3'd7);
  assign w_commit    = (r_state == ST_COMMIT);

  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Converter next state: dat1 for 8 steps, dat2 for 8 steps, then commit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_snap)      w_state_nxt = ST_CONV1;
      ST_CONV1:  if (w_step_last) w_state_nxt = ST_CONV2;
      ST_CONV2:  if (w_step_last) w_state_nxt = ST_COMMIT;
      ST_COMMIT:                  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Converter datapath; dat2 is held in r_snap2 so both fields share one snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step  <= 3'd0;
      r_bin   <= 8'd0;
      r_bcd   <= 12'd0;
      r_bcd1  <= 12'd0;
      r_snap2 <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_snap) begin
            r_bin   <= dat1;
            r_snap2 <= dat2;
            r_bcd   <= 12'd0;
            r_step  <= 3'd0;
          end
        end
        ST_CONV1: begin
          r_step <= r_step + 3'd1;
          if (w_step_last) begin
            r_bcd1 <= w_bcd_sh;
            r_bcd  <= 12'd0;
            r_bin  <= r_snap2;
          end else begin
            r_bcd  <= w_bcd_sh;
            r_bin  <= w_bin_sh;
          end
        end
        ST_CONV2: begin
          r_step <= r_step + 3'd1;
          r_bcd  <= w_bcd_sh;
          r_bin  <= w_bin_sh;
        end
        default: ;
      endcase
    end
  end

  // All four digit patterns change together in the commit cycle (no tearing)
  always_comb begin
    w_pat_nxt = r_pat;
    if (w_commit) begin
      w_pat_nxt[3:2] = f_field(r_bcd1);
      w_pat_nxt[1:0] = f_field(r_bcd);
    end
  end

  // Output drive is computed from next-cycle state so the registered pins
  // line up with the divider/index registers.
  always_comb begin
    w_lit    = (w_div_nxt >= c_blank);
    w_seg_on = w_lit ? {1'b0, w_pat_nxt[w_idx_nxt]} : 8'h00;
    w_sel_on = w_lit ? (4'b0001 << w_idx_nxt) : 4'h0;
  end

  // Displayed digits and polarity-adjusted output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat     <= {4{f_digit(4'd0)}};
      r_seg_out <= c_seg_off;
      r_sel     <= c_sel_off;
    end else begin
      r_pat     <= w_pat_nxt;
      r_seg_out <= SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
      r_sel     <= SEL_ACTIVE_LOW ? ~w_sel_on : w_sel_on;
    end
  end

  assign seg_out = r_seg_out;
  assign sel     = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Self-checking bench for seg_scan_driver. A time-based reference
//            model (edge count -> slot position, digit index, frame start)
//            predicts sel/seg_out every clock from decimal arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int c_scan_div = 99;
  localparam int c_blank    = 4;
  localparam int c_slot     = c_scan_div + 1;
  localparam int c_frame    = 4 * c_slot;
  localparam int c_latency  = 17;

  logic       clk;
  logic       rst_n;
  logic [7:0] dat1;
  logic [7:0] dat2;
  logic [7:0] seg_out;
  logic [3:0] sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: t = clock edges since reset release
  int t;
  int commit_at;
  int snap1, snap2;
  int show1, show2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV      (c_scan_div),
    .BLANK_CYC     (c_blank),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dat1   (dat1),
    .dat2   (dat2),
    .seg_out(seg_out),
    .sel    (sel)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] field_pat(input int v, input bit tens);
    if (v > 99) return 7'h40;
    return digit_pat(tens ? (v / 10) : (v % 10));
  endfunction

  function automatic logic [7:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd99;
      2:       return 8'd100;
      3:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(0, 99));
    endcase
  endfunction

  task automatic model_reset();
    t         = 0;
    commit_at = -1;
    snap1     = 0;
    snap2     = 0;
    show1     = 0;
    show2     = 0;
  endtask

  // Called right after each rising edge
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      t++;
      if (t == 1 || (t % c_frame) == 0) begin
        snap1     = dat1;
        snap2     = dat2;
        commit_at = t + c_latency;
      end
      if (t == commit_at) begin
        show1 = snap1;
        show2 = snap2;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] es;
    logic [3:0] ev;
    logic [3:0] one_hot;
    int pos, idx, v;
    pos = t % c_slot;
    idx = (t / c_slot) % 4;
    if (!rst_n || pos < c_blank) begin
      es = 8'hFF;
      ev = 4'hF;
    end else begin
      one_hot = 4'b0001 << idx;
      ev      = ~one_hot;
      v       = (idx < 2) ? show2 : show1;
      es      = ~{1'b0, field_pat(v, (idx % 2) == 1)};
    end
    check_eq({tag, "_sel"}, {4'h0, sel}, {4'h0, ev});
    check_eq({tag, "_seg"}, seg_out, es);
  endtask

  // One clock: model update at the edge, check 1 ns later, drive 2 ns later
  task automatic step(input string tag, input bit churn);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    #1;
    if (churn && $urandom_range(0, 199) == 0) begin
      dat1 = rand_val();
      dat2 = rand_val();
    end
  endtask

  task automatic run(input string tag, input int n, input bit churn);
    repeat (n) step(tag, churn);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b1;
    dat1  = 8'd22;
    dat2  = 8'd7;
    #1 rst_n = 1'b0;

    run("reset", 3, 1'b0);
    rst_n = 1'b1;
    run("d22_7", 2 * c_frame, 1'b0);

    dat1 = 8'd99;  dat2 = 8'd99;
    run("d99_99", c_frame + 50, 1'b0);
    dat1 = 8'd0;   dat2 = 8'd0;
    run("d0_0", c_frame, 1'b0);
    dat1 = 8'd150; dat2 = 8'd0;
    run("d150_0", c_frame, 1'b0);
    dat1 = 8'd100; dat2 = 8'd255;
    run("d100_255", c_frame, 1'b0);

    // Change dat1 while digit 1 is being scanned
    dat1 = 8'd22;  dat2 = 8'd7;
    run("midframe_pre", c_frame, 1'b0);
    while ((t % c_frame) != 150) step("midframe_pre", 1'b0);
    dat1 = 8'd33;
    run("midframe", 2 * c_frame, 1'b0);

    run("random", 8 * c_frame, 1'b1);

    // Asynchronous reset in the middle of slot 2
    while ((t % c_frame) != 250) step("pre_async", 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    run("in_reset", 3, 1'b0);
    rst_n = 1'b1;
    dat1  = rand_val();
    dat2  = rand_val();
    run("post_reset", 2 * c_frame, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
